// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station.
// Holds the default ROB sizing, the command and data widths, and the
// rs_entry_t record used for each reservation-station slot.
// Tag fields in rs_entry_t are sized from ROB_SIZE here. The top module
// size-casts its ROBsizeLog-wide ports onto these fields.
package alu_reservation_station_pkg;

    localparam int ROB_SIZE  = 8;
    localparam int ROB_TAG_W = $clog2(ROB_SIZE + 1);
    localparam int CMD_W     = 10;
    localparam int DATA_W    = 64;

    typedef struct packed {
        logic                 valid;
        logic [CMD_W-1:0]     commands;
        logic [ROB_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    val1;
        logic                 rdy1;
        logic [ROB_TAG_W-1:0] src1;
        logic [DATA_W-1:0]    val2;
        logic                 rdy2;
        logic [ROB_TAG_W-1:0] src2;
        logic [DATA_W-1:0]    val3;
    } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_rs_priority_pick.sv
// Lowest-index-first priority picker.
// Ports:
//   req     : request vector, one bit per reservation-station entry
//   grant   : one-hot grant for the lowest set request bit (zero if none)
//   index   : binary index of the granted bit (zero if none)
//   any_req : at least one request bit is set
// The top module uses this picker twice: once to find a free slot for
// dispatch, and once to choose the entry to issue.
module rs_priority_pick #(
    parameter int WIDTH = 4,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic [IDXW-1:0]  index,
    output logic             any_req
);

    // The loop scans from high index to low index so the lowest set bit is written last and wins.
    always_comb begin
        grant   = '0;
        index   = '0;
        any_req = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = IDXW'(i);
                any_req  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station that buffers dispatched ALU operations until both
// source operands are valid, then presents them to the issue stage.
// Ports:
//   clk_i, reset_i (synchronous, active low)
//   dispatch*_i    : new operation from dispatch; the entry carries its
//                    operand values, or the producer tags of operands that
//                    are not yet ready
//   rsFull_o, rsCount_o : occupancy, taken from registered state only
//   cdb*_i         : result broadcast used to wake up waiting operands
//   flush_i        : discard every entry
//   readyRS_o, reservationStation*_o, RSVal3_o : the selected issuable entry
//   stallRS_i      : the issue stage cannot accept a transfer this cycle
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int ROBsize    = ROB_SIZE,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int RSdepth    = 4,
    localparam int CNTW      = $clog2(RSdepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  dispatchValid_i,
    input  logic [CMD_W-1:0]      dispatchCommands_i,
    input  logic [ROBsizeLog-1:0] dispatchTag_i,
    input  logic [DATA_W-1:0]     dispatchVal1_i,
    input  logic [DATA_W-1:0]     dispatchVal2_i,
    input  logic                  dispatchRdy1_i,
    input  logic                  dispatchRdy2_i,
    input  logic [ROBsizeLog-1:0] dispatchSrc1_i,
    input  logic [ROBsizeLog-1:0] dispatchSrc2_i,
    input  logic [DATA_W-1:0]     dispatchVal3_i,
    output logic                  rsFull_o,
    output logic [CNTW-1:0]       rsCount_o,
    input  logic                  cdbValid_i,
    input  logic [ROBsizeLog-1:0] cdbTag_i,
    input  logic [DATA_W-1:0]     cdbVal_i,
    input  logic                  flush_i,
    output logic                  readyRS_o,
    output logic [DATA_W-1:0]     reservationStationVal1_o,
    output logic [DATA_W-1:0]     reservationStationVal2_o,
    output logic [DATA_W-1:0]     RSVal3_o,
    output logic [CMD_W-1:0]      reservationStationCommands_o,
    output logic [ROBsizeLog-1:0] reservationStationTag_o,
    input  logic                  stallRS_i
);

    localparam int IDXW = (RSdepth > 1) ? $clog2(RSdepth) : 1;

    rs_entry_t            entries [RSdepth];
    rs_entry_t            dispatch_entry;
    rs_entry_t            sel_entry;
    logic [RSdepth-1:0]   valid_vec;
    logic [RSdepth-1:0]   issuable_vec;
    logic [RSdepth-1:0]   issue_grant;
    logic [RSdepth-1:0]   free_grant;
    logic [IDXW-1:0]      issue_idx;
    logic [IDXW-1:0]      free_idx;
    logic                 issue_any;
    logic                 free_any;
    logic                 dispatch_en;
    logic                 transfer;
    logic [ROB_TAG_W-1:0] cdb_tag;
    logic                 unused_free_idx;

    // Per-entry status bits. These come only from registered state, so issue selection and occupancy never see same-cycle inputs.
    always_comb begin
        valid_vec    = '0;
        issuable_vec = '0;
        for (int i = 0; i < RSdepth; i++) begin
            valid_vec[i]    = entries[i].valid;
            issuable_vec[i] = entries[i].valid & entries[i].rdy1 & entries[i].rdy2;
        end
    end

    rs_priority_pick #(.WIDTH(RSdepth), .IDXW(IDXW)) u_free_pick (
        .req     (~valid_vec),
        .grant   (free_grant),
        .index   (free_idx),
        .any_req (free_any)
    );

    rs_priority_pick #(.WIDTH(RSdepth), .IDXW(IDXW)) u_issue_pick (
        .req     (issuable_vec),
        .grant   (issue_grant),
        .index   (issue_idx),
        .any_req (issue_any)
    );

    assign unused_free_idx = ^free_idx;
    assign cdb_tag         = ROB_TAG_W'(cdbTag_i);

    // The free slot is chosen from registered valid bits, so a slot that is freed in this cycle cannot be reused until the next one.
    assign dispatch_en = dispatchValid_i & free_any & ~flush_i;
    assign transfer    = issue_any & ~stallRS_i;

    // Build the new entry. An operand that arrives not-ready but whose producer is on the CDB in this cycle is written as ready with the CDB value.
    always_comb begin
        dispatch_entry          = '0;
        dispatch_entry.valid    = 1'b1;
        dispatch_entry.commands = dispatchCommands_i;
        dispatch_entry.tag      = ROB_TAG_W'(dispatchTag_i);
        dispatch_entry.src1     = ROB_TAG_W'(dispatchSrc1_i);
        dispatch_entry.src2     = ROB_TAG_W'(dispatchSrc2_i);
        dispatch_entry.val3     = dispatchVal3_i;
        dispatch_entry.val1     = dispatchVal1_i;
        dispatch_entry.rdy1     = dispatchRdy1_i;
        dispatch_entry.val2     = dispatchVal2_i;
        dispatch_entry.rdy2     = dispatchRdy2_i;
        if (!dispatchRdy1_i && cdbValid_i && (cdbTag_i == dispatchSrc1_i)) begin
            dispatch_entry.val1 = cdbVal_i;
            dispatch_entry.rdy1 = 1'b1;
        end
        if (!dispatchRdy2_i && cdbValid_i && (cdbTag_i == dispatchSrc2_i)) begin
            dispatch_entry.val2 = cdbVal_i;
            dispatch_entry.rdy2 = 1'b1;
        end
    end

    // Entry storage. Reset and flush clear only the valid bits; the payload fields are don't-care while an entry is invalid.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < RSdepth; i++) entries[i].valid <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < RSdepth; i++) entries[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < RSdepth; i++) begin
                if (entries[i].valid) begin
                    if (!entries[i].rdy1 && cdbValid_i && (cdb_tag == entries[i].src1)) begin
                        entries[i].val1 <= cdbVal_i;
                        entries[i].rdy1 <= 1'b1;
                    end
                    if (!entries[i].rdy2 && cdbValid_i && (cdb_tag == entries[i].src2)) begin
                        entries[i].val2 <= cdbVal_i;
                        entries[i].rdy2 <= 1'b1;
                    end
                    if (transfer && issue_grant[i]) entries[i].valid <= 1'b0;
                end else if (dispatch_en && free_grant[i]) begin
                    entries[i] <= dispatch_entry;
                end
            end
        end
    end

    // Occupancy is counted from registered valid bits.
    always_comb begin
        rsCount_o = '0;
        for (int i = 0; i < RSdepth; i++) rsCount_o = rsCount_o + CNTW'(valid_vec[i]);
    end

    assign rsFull_o  = &valid_vec;
    assign sel_entry = entries[issue_idx];
    assign readyRS_o = issue_any;

    // The issue outputs are forced to zero when no entry is issuable, so stale payload from invalid slots never reaches the outputs.
    always_comb begin
        reservationStationVal1_o     = '0;
        reservationStationVal2_o     = '0;
        RSVal3_o                     = '0;
        reservationStationCommands_o = '0;
        reservationStationTag_o      = '0;
        if (issue_any) begin
            reservationStationVal1_o     = sel_entry.val1;
            reservationStationVal2_o     = sel_entry.val2;
            RSVal3_o                     = sel_entry.val3;
            reservationStationCommands_o = sel_entry.commands;
            reservationStationTag_o      = ROBsizeLog'(sel_entry.tag);
        end
    end

endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter ROBsize, default 8, ROB entry count.
REQ-002 Parameter ROBsizeLog, default $clog2(ROBsize+1), tag width.
REQ-003 Parameter RSdepth, default 4, number of entries; CNTW = $clog2(RSdepth+1).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 reset_i  in  1  synchronous, active-low reset (0 = reset).
REQ-006 dispatchValid_i  in  1  dispatch request this cycle.
REQ-007 dispatchCommands_i  in  10  ALU command word; dispatchTag_i  in  ROBsizeLog  destination ROB tag.
REQ-008 dispatchVal1_i / dispatchVal2_i  in  64 each  operand values; dispatchRdy1_i / dispatchRdy2_i  in  1 each  value valid; dispatchSrc1_i / dispatchSrc2_i  in  ROBsizeLog each  producer tag when not ready.
REQ-009 dispatchVal3_i  in  64  pass-through value, always ready.
REQ-010 rsFull_o  out  1  all entries valid; rsCount_o  out  CNTW  occupied entries.
REQ-011 cdbValid_i  in  1, cdbTag_i  in  ROBsizeLog, cdbVal_i  in  64  result broadcast.
REQ-012 flush_i  in  1  discard all entries.
REQ-013 readyRS_o  out  1  an issuable entry is presented.
REQ-014 reservationStationVal1_o / Val2_o / RSVal3_o  out  64 each; reservationStationCommands_o  out  10; reservationStationTag_o  out  ROBsizeLog.
REQ-015 stallRS_i  in  1  issue stage cannot accept this cycle.

Function
REQ-016 Entry fields: valid, commands, tag, val1/rdy1/src1, val2/rdy2/src2, val3.
REQ-017 Dispatch: dispatchValid_i & ~rsFull_o & ~flush_i writes lowest-index invalid entry; dispatch while rsFull_o=1 is dropped.
REQ-018 Wakeup: each valid entry with rdyN=0 and cdbValid_i & cdbTag_i==srcN latches cdbVal_i, sets rdyN=1.
REQ-019 Dispatch bypass: operand dispatched not-ready whose src matches same-cycle CDB is written ready with cdbVal_i.
REQ-020 Entry issuable when valid & rdy1 & rdy2, evaluated on registered state; CDB wakeup in cycle N issuable earliest N+1.
REQ-021 Select: lowest-index issuable entry; readyRS_o = any issuable; outputs combinational from selected entry, all zero when none.
REQ-022 readyRS_o and data outputs SHALL NOT depend combinationally on stallRS_i, CDB, or dispatch inputs.
REQ-023 Transfer occurs when readyRS_o & ~stallRS_i; selected entry invalid next cycle; no transfer otherwise, outputs held stable while stalled unless a lower-index entry becomes issuable.
REQ-024 Freed entry not reusable by dispatch in same cycle; rsFull_o/rsCount_o registered-state derived.
REQ-025 Simultaneous transfer and dispatch: rsCount_o unchanged next cycle.
REQ-026 flush_i: all valid bits cleared next cycle; dominates dispatch, wakeup, and transfer.

Reset
REQ-027 reset_i=0 at clock edge: all valid bits 0; readyRS_o=0, rsFull_o=0, rsCount_o=0, all data outputs 0 next cycle.
REQ-028 Reset mid-operation discards all entries; no transfer recorded in reset cycle.
REQ-029 Entry payload fields need no reset; valid bits must.

Structure
REQ-030 Shared package: ROB parameters, command width 10, data width 64, rs_entry_t struct.
REQ-031 One sub-module rs_priority_pick: RSdepth-bit request vector -> one-hot grant + index + any, used for both free-slot and issue selection.

Verification
REQ-032 Dispatch cmd=10, tag=3, val1=15, val2=3, both ready, stallRS_i=0 -> readyRS_o=1 next cycle with those values; entry freed cycle after.
REQ-033 Dispatch tag=2 src1=5 not ready; cdbValid_i, cdbTag_i=5, cdbVal_i=0x77 two cycles later -> readyRS_o=1 cycle after CDB, Val1=0x77.
REQ-034 Fill 4 entries, dispatch 5th -> rsFull_o=1, rsCount_o=4, 5th dropped; hold stallRS_i=1 -> outputs stable, no entry freed.
REQ-035 Dispatch with src2=6 and same-cycle cdbTag_i=6 -> entry issuable next cycle, Val2=cdbVal_i.
REQ-036 Entries 0 and 2 issuable, stallRS_i=0 -> entry 0 issued first, entry 2 next cycle.
REQ-037 3 entries valid, assert flush_i with dispatchValid_i=1 -> rsCount_o=0, readyRS_o=0 next cycle; reset_i=0 mid-stream same result.
